// File: rtl/alu_board_ctrl.sv
// Board front end for the ALU lab: debounced one-shot button loads of A, B and
// opcode from the shared switch bank, a combinational ALU and a registered result.
module alu_board_ctrl #(
  parameter int LEN_DATO        = 8,
  parameter int LEN_OP          = 6,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LEN_CNT         = 16
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic signed [LEN_DATO-1:0] i_switch,
  input  logic        [2:0]          i_buttons,
  output logic signed [LEN_DATO-1:0] o_led,
  output logic                       o_zero,
  output logic                       o_carry,
  output logic                       o_overflow,
  output logic                       o_invalid,
  output logic        [2:0]          o_loaded
);

  localparam int MSB = LEN_DATO - 1;

  localparam logic [LEN_OP-1:0] OP_ADD = LEN_OP'(6'b100000);
  localparam logic [LEN_OP-1:0] OP_SUB = LEN_OP'(6'b100010);
  localparam logic [LEN_OP-1:0] OP_AND = LEN_OP'(6'b100100);
  localparam logic [LEN_OP-1:0] OP_OR  = LEN_OP'(6'b100101);
  localparam logic [LEN_OP-1:0] OP_XOR = LEN_OP'(6'b100110);
  localparam logic [LEN_OP-1:0] OP_NOR = LEN_OP'(6'b100111);
  localparam logic [LEN_OP-1:0] OP_SRA = LEN_OP'(6'b000011);
  localparam logic [LEN_OP-1:0] OP_SRL = LEN_OP'(6'b000010);

  localparam logic [LEN_CNT-1:0]  CNT_LAST  = LEN_CNT'(DEBOUNCE_CYCLES - 1);
  localparam logic [LEN_DATO-1:0] SHIFT_LIM = LEN_DATO'(LEN_DATO);

  // Button conditioning state, indexed like i_buttons
  logic [2:0]              sync1_q, sync1_d;
  logic [2:0]              sync2_q, sync2_d;
  logic [2:0]              deb_q, deb_d;
  logic [2:0]              deb_prev_q, deb_prev_d;
  logic [2:0][LEN_CNT-1:0] cnt_q, cnt_d;
  logic [2:0]              pulse;

  // Operand / result state
  logic [LEN_DATO-1:0] a_q, a_d;
  logic [LEN_DATO-1:0] b_q, b_d;
  logic [LEN_OP-1:0]   op_q, op_d;
  logic [2:0]          loaded_q, loaded_d;
  logic [LEN_DATO-1:0] led_q, led_d;
  logic                zero_q, zero_d;
  logic                carry_q, carry_d;
  logic                ovf_q, ovf_d;
  logic                inv_q, inv_d;

  logic [LEN_DATO:0]   sum, diff;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sync1_d    = i_buttons;
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    cnt_d      = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + LEN_CNT'(1);
        end
      end
    end
    pulse = deb_q & ~deb_prev_q;
  end

  // Only the highest-priority pulse (A > B > opcode) is honoured
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    loaded_d = loaded_q;
    if (pulse[2]) begin
      a_d         = i_switch;
      loaded_d[2] = 1'b1;
    end else if (pulse[1]) begin
      b_d         = i_switch;
      loaded_d[1] = 1'b1;
    end else if (pulse[0]) begin
      op_d        = i_switch[LEN_OP-1:0];
      loaded_d[0] = 1'b1;
    end
  end

  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = {1'b0, a_q} - {1'b0, b_q};
    led_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    inv_d   = 1'b0;
    case (op_q)
      OP_ADD: begin
        led_d   = sum[MSB:0];
        carry_d = sum[LEN_DATO];
        ovf_d   = (a_q[MSB] == b_q[MSB]) && (led_d[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        led_d   = diff[MSB:0];
        carry_d = diff[LEN_DATO];
        ovf_d   = (a_q[MSB] != b_q[MSB]) && (led_d[MSB] != a_q[MSB]);
      end
      OP_AND: led_d = a_q & b_q;
      OP_OR:  led_d = a_q | b_q;
      OP_XOR: led_d = a_q ^ b_q;
      OP_NOR: led_d = ~(a_q | b_q);
      OP_SRA: begin
        // Kept out of a ?: so the unsigned fill term cannot turn this into a logical shift
        if (b_q >= SHIFT_LIM) led_d = {LEN_DATO{a_q[MSB]}};
        else                  led_d = $signed(a_q) >>> b_q;
      end
      OP_SRL: begin
        if (b_q >= SHIFT_LIM) led_d = '0;
        else                  led_d = a_q >> b_q;
      end
      default: inv_d = 1'b1;
    endcase
    zero_d = (led_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      loaded_q   <= '0;
      led_q      <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      ovf_q      <= 1'b0;
      inv_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      loaded_q   <= loaded_d;
      led_q      <= led_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      ovf_q      <= ovf_d;
      inv_q      <= inv_d;
    end
  end

  assign o_led      = led_q;
  assign o_zero     = zero_q;
  assign o_carry    = carry_q;
  assign o_overflow = ovf_q;
  assign o_invalid  = inv_q;
  assign o_loaded   = loaded_q;

endmodule
